// File: rtl/dm_load_ext_pkg.sv
// Shared encodings for the memory-stage load/store datapath: access widths
// (also used by the store byte-enable encoder) and load FSM states.
package dm_load_ext_pkg;

    localparam logic [1:0] WIDTH_WORD = 2'b00;
    localparam logic [1:0] WIDTH_HALF = 2'b01;
    localparam logic [1:0] WIDTH_BYTE = 2'b10;
    localparam logic [1:0] WIDTH_RSVD = 2'b11;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_e;

    // A half must sit on an even address and a word on a 4-byte boundary.
    function automatic logic isMisaligned(input logic [1:0] width, input logic [1:0] addrLo);
        return ((width == WIDTH_HALF) && addrLo[0]) ||
               ((width == WIDTH_WORD) && (addrLo != 2'b00));
    endfunction

endpackage

// File: rtl/load_lane_ext.sv
// Picks the addressed byte/half/word out of a little-endian read word and
// sign- or zero-extends it to 32 bits; the reserved width yields zero.
module load_lane_ext
    import dm_load_ext_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addrLo,
    input  logic [1:0]  width,
    input  logic        sign,
    output logic [31:0] extData
);

    logic [15:0] halfSel;
    logic [7:0]  byteSel;

    always_comb begin
        halfSel = addrLo[1] ? rdata[31:16] : rdata[15:0];
        byteSel = rdata[7:0];
        case (addrLo)
            2'b00:   byteSel = rdata[7:0];
            2'b01:   byteSel = rdata[15:8];
            2'b10:   byteSel = rdata[23:16];
            default: byteSel = rdata[31:24];
        endcase

        extData = '0;
        case (width)
            WIDTH_WORD: extData = rdata;
            WIDTH_HALF: extData = {{16{sign & halfSel[15]}}, halfSel};
            WIDTH_BYTE: extData = {{24{sign & byteSel[7]}}, byteSel};
            default:    extData = '0;
        endcase
    end

endmodule

// File: rtl/dm_load_ext.sv
// Memory-stage load unit: waits for the read-data handshake, stalls the pipe
// meanwhile, and hands a registered extended result to W. Optional macro
// DM_LOAD_ALIGN_CHECK_EN rejects misaligned half/word loads without a read.
module dm_load_ext
    import dm_load_ext_pkg::*;
#(
    parameter int MAX_WAIT = 15,
    parameter int CNT_W    = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic [31:0] req_addr,
    input  logic [1:0]  req_width,
    input  logic        req_sign,
    input  logic [4:0]  req_rd,
    input  logic [31:0] m_data_rdata,
    input  logic        m_data_rvalid,
    output logic        busy,
    output logic        out_valid,
    output logic [31:0] out_data,
    output logic [4:0]  out_rd,
    output logic        out_err
);

    state_e      state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [1:0]  capAddr_q;
    logic [1:0]  capWidth_q;
    logic        capSign_q;
    logic [4:0]  capRd_q;
    logic        outValid_q;
    logic [31:0] outData_q;
    logic [4:0]  outRd_q;
    logic        outErr_q;
    logic [31:0] extData_d;

    logic unusedAddrHi;
    assign unusedAddrHi = ^req_addr[31:2];

    load_lane_ext u_lane (
        .rdata   (m_data_rdata),
        .addrLo  (capAddr_q),
        .width   (capWidth_q),
        .sign    (capSign_q),
        .extData (extData_d)
    );

    // Single FSM block; out_valid defaults low so every completion is one pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            capAddr_q  <= '0;
            capWidth_q <= '0;
            capSign_q  <= 1'b0;
            capRd_q    <= '0;
            outValid_q <= 1'b0;
            outData_q  <= '0;
            outRd_q    <= '0;
            outErr_q   <= 1'b0;
        end else begin
            outValid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (req_valid) begin
                        capAddr_q  <= req_addr[1:0];
                        capWidth_q <= req_width;
                        capSign_q  <= req_sign;
                        capRd_q    <= req_rd;
                        cnt_q      <= '0;
`ifdef DM_LOAD_ALIGN_CHECK_EN
                        if (isMisaligned(req_width, req_addr[1:0])) begin
                            outValid_q <= 1'b1;
                            outErr_q   <= 1'b1;
                            outData_q  <= '0;
                            outRd_q    <= req_rd;
                        end else begin
                            state_q <= ST_WAIT;
                        end
`else
                        state_q <= ST_WAIT;
`endif
                    end
                end
                ST_WAIT: begin
                    if (m_data_rvalid) begin
                        outValid_q <= 1'b1;
                        outData_q  <= extData_d;
                        outErr_q   <= (capWidth_q == WIDTH_RSVD);
                        outRd_q    <= capRd_q;
                        state_q    <= ST_IDLE;
                    end else if (cnt_q == CNT_W'(MAX_WAIT - 1)) begin
                        outValid_q <= 1'b1;
                        outData_q  <= '0;
                        outErr_q   <= 1'b1;
                        outRd_q    <= capRd_q;
                        cnt_q      <= '0;
                        state_q    <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
            endcase
        end
    end

    assign busy      = (state_q == ST_WAIT);
    assign out_valid = outValid_q;
    assign out_data  = outData_q;
    assign out_rd    = outRd_q;
    assign out_err   = outErr_q;

endmodule

// File: tb/tb_dm_load_ext.sv
// Directed self-checking bench for dm_load_ext: extension cases, stall length,
// back-to-back requests, timeout, reset mid-read and the alignment option.
module tb_dm_load_ext;
   import dm_load_ext_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid;
   logic [31:0] req_addr;
   logic [1:0]  req_width;
   logic        req_sign;
   logic [4:0]  req_rd;
   logic [31:0] m_data_rdata;
   logic        m_data_rvalid;
   logic        busy;
   logic        out_valid;
   logic [31:0] out_data;
   logic [4:0]  out_rd;
   logic        out_err;

   int errors = 0;
   int checks = 0;

   dm_load_ext #(.MAX_WAIT(15), .CNT_W(4)) dut (
      .clk           (clk),
      .reset         (reset),
      .req_valid     (req_valid),
      .req_addr      (req_addr),
      .req_width     (req_width),
      .req_sign      (req_sign),
      .req_rd        (req_rd),
      .m_data_rdata  (m_data_rdata),
      .m_data_rvalid (m_data_rvalid),
      .busy          (busy),
      .out_valid     (out_valid),
      .out_data      (out_data),
      .out_rd        (out_rd),
      .out_err       (out_err)
   );

   always #5 clk = ~clk;

   // Every comparison goes through here so the counters stay in one place.
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic v, input logic [31:0] a, input logic [1:0] w,
                                input logic s, input logic [4:0] r);
      req_valid = v;
      req_addr  = a;
      req_width = w;
      req_sign  = s;
      req_rd    = r;
   endtask

   // One complete load: request, 'delay' idle wait cycles, then an rvalid pulse.
   task automatic runLoad(input string tag, input logic [31:0] a, input logic [1:0] w,
                          input logic s, input logic [4:0] r, input logic [31:0] rdata,
                          input int delay, input logic [31:0] expData, input logic expErr);
      int busyCnt;
      busyCnt = 0;
      applyStimulus(1'b1, a, w, s, r);
      @(negedge clk);
      applyStimulus(1'b0, 32'h0, 2'b00, 1'b0, 5'd0);
      for (int i = 0; i < delay; i++) begin
         if (busy) busyCnt++;
         checkOutput({tag, ".nopulse"}, {31'b0, out_valid}, 32'd0);
         @(negedge clk);
      end
      if (busy) busyCnt++;
      m_data_rvalid = 1'b1;
      m_data_rdata  = rdata;
      @(negedge clk);
      m_data_rvalid = 1'b0;
      m_data_rdata  = 32'h5A5A5A5A;
      checkOutput({tag, ".valid"}, {31'b0, out_valid}, 32'd1);
      checkOutput({tag, ".data"}, out_data, expData);
      checkOutput({tag, ".err"}, {31'b0, out_err}, {31'b0, expErr});
      checkOutput({tag, ".rd"}, {27'b0, out_rd}, {27'b0, r});
      checkOutput({tag, ".busyIdle"}, {31'b0, busy}, 32'd0);
      checkOutput({tag, ".busyCycles"}, busyCnt, delay + 1);
      @(negedge clk);
      checkOutput({tag, ".pulseEnd"}, {31'b0, out_valid}, 32'd0);
      checkOutput({tag, ".hold"}, out_data, expData);
   endtask

   initial begin
      int busyCnt;
      bit done;

      reset = 1'b1;
      m_data_rvalid = 1'b0;
      m_data_rdata  = 32'h0;
      applyStimulus(1'b0, 32'h0, 2'b00, 1'b0, 5'd0);
      #1;
      checkOutput("reset.busy",  {31'b0, busy},      32'd0);
      checkOutput("reset.valid", {31'b0, out_valid}, 32'd0);
      checkOutput("reset.data",  out_data,           32'd0);
      checkOutput("reset.rd",    {27'b0, out_rd},    32'd0);
      checkOutput("reset.err",   {31'b0, out_err},   32'd0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);

      runLoad("lb3",   32'h1003, WIDTH_BYTE, 1'b1, 5'd1, 32'h80FF1234, 0, 32'hFFFFFF80, 1'b0);
      runLoad("lhu2",  32'h2002, WIDTH_HALF, 1'b0, 5'd2, 32'h8001ABCD, 3, 32'h00008001, 1'b0);
      runLoad("lbu1",  32'h3001, WIDTH_BYTE, 1'b0, 5'd3, 32'h80FF1234, 1, 32'h00000012, 1'b0);
      runLoad("lbu2",  32'h3002, WIDTH_BYTE, 1'b0, 5'd4, 32'h80FF1234, 0, 32'h000000FF, 1'b0);
      runLoad("lb0",   32'h3000, WIDTH_BYTE, 1'b1, 5'd6, 32'h0000007F, 0, 32'h0000007F, 1'b0);
      runLoad("lh0",   32'h4000, WIDTH_HALF, 1'b1, 5'd7, 32'h8001ABCD, 2, 32'hFFFFABCD, 1'b0);
      runLoad("lh2",   32'h4002, WIDTH_HALF, 1'b1, 5'd8, 32'h8001ABCD, 0, 32'hFFFF8001, 1'b0);
      runLoad("rsvd",  32'h5000, WIDTH_RSVD, 1'b0, 5'd10, 32'h12345678, 1, 32'h00000000, 1'b1);

      // Back-to-back: a second request arrives in the out_valid cycle.
      applyStimulus(1'b1, 32'h100, WIDTH_WORD, 1'b0, 5'd5);
      @(negedge clk);
      applyStimulus(1'b0, 32'h0, 2'b00, 1'b0, 5'd0);
      m_data_rvalid = 1'b1;
      m_data_rdata  = 32'hDEADBEEF;
      @(negedge clk);
      m_data_rvalid = 1'b0;
      checkOutput("b2b.first.valid", {31'b0, out_valid}, 32'd1);
      checkOutput("b2b.first.data",  out_data,           32'hDEADBEEF);
      checkOutput("b2b.first.rd",    {27'b0, out_rd},    32'd5);
      applyStimulus(1'b1, 32'h204, WIDTH_BYTE, 1'b0, 5'd9);
      @(negedge clk);
      applyStimulus(1'b0, 32'h0, 2'b00, 1'b0, 5'd0);
      checkOutput("b2b.accepted.busy", {31'b0, busy},      32'd1);
      checkOutput("b2b.gap.valid",     {31'b0, out_valid}, 32'd0);
      checkOutput("b2b.gap.rd",        {27'b0, out_rd},    32'd5);
      m_data_rvalid = 1'b1;
      m_data_rdata  = 32'h000000A5;
      @(negedge clk);
      m_data_rvalid = 1'b0;
      checkOutput("b2b.second.valid", {31'b0, out_valid}, 32'd1);
      checkOutput("b2b.second.data",  out_data,           32'h000000A5);
      checkOutput("b2b.second.rd",    {27'b0, out_rd},    32'd9);
      @(negedge clk);
      checkOutput("b2b.second.pulseEnd", {31'b0, out_valid}, 32'd0);

`ifdef DM_LOAD_ALIGN_CHECK_EN
      applyStimulus(1'b1, 32'h6001, WIDTH_HALF, 1'b1, 5'd11);
      @(negedge clk);
      applyStimulus(1'b0, 32'h0, 2'b00, 1'b0, 5'd0);
      checkOutput("align.busy",  {31'b0, busy},      32'd0);
      checkOutput("align.valid", {31'b0, out_valid}, 32'd1);
      checkOutput("align.err",   {31'b0, out_err},   32'd1);
      checkOutput("align.data",  out_data,           32'd0);
      checkOutput("align.rd",    {27'b0, out_rd},    32'd11);
      @(negedge clk);
      checkOutput("align.pulseEnd", {31'b0, out_valid}, 32'd0);
      checkOutput("align.busyAfter", {31'b0, busy}, 32'd0);
`else
      runLoad("lhMis", 32'h6001, WIDTH_HALF, 1'b1, 5'd11, 32'h8001ABCD, 0, 32'hFFFFABCD, 1'b0);
`endif

      // Timeout: never answer; the unit should give up after 15 wait cycles.
      applyStimulus(1'b1, 32'h7000, WIDTH_WORD, 1'b0, 5'd7);
      @(negedge clk);
      applyStimulus(1'b0, 32'h0, 2'b00, 1'b0, 5'd0);
      busyCnt = 0;
      done = 1'b0;
      for (int i = 0; i < 40 && !done; i++) begin
         if (out_valid) done = 1'b1;
         else begin
            if (busy) busyCnt++;
            @(negedge clk);
         end
      end
      checkOutput("timeout.reached",    {31'b0, done},    32'd1);
      checkOutput("timeout.busyCycles", busyCnt,          32'd15);
      checkOutput("timeout.err",        {31'b0, out_err}, 32'd1);
      checkOutput("timeout.data",       out_data,         32'd0);
      checkOutput("timeout.rd",         {27'b0, out_rd},  32'd7);
      checkOutput("timeout.busyIdle",   {31'b0, busy},    32'd0);
      m_data_rvalid = 1'b1;
      m_data_rdata  = 32'h11223344;
      @(negedge clk);
      m_data_rvalid = 1'b0;
      checkOutput("stray.valid", {31'b0, out_valid}, 32'd0);
      @(negedge clk);
      checkOutput("stray.valid2", {31'b0, out_valid}, 32'd0);
      checkOutput("stray.data",   out_data,           32'd0);
      checkOutput("stray.busy",   {31'b0, busy},      32'd0);

      // Reset in the middle of a read, then a late rvalid that must be dropped.
      runLoad("lwPre", 32'h8000, WIDTH_WORD, 1'b0, 5'd12, 32'hCAFEF00D, 0, 32'hCAFEF00D, 1'b0);
      applyStimulus(1'b1, 32'h9000, WIDTH_WORD, 1'b0, 5'd13);
      @(negedge clk);
      applyStimulus(1'b0, 32'h0, 2'b00, 1'b0, 5'd0);
      @(negedge clk);
      checkOutput("rstWait.busyBefore", {31'b0, busy}, 32'd1);
      reset = 1'b1;
      #1;
      checkOutput("rstWait.busy", {31'b0, busy},    32'd0);
      checkOutput("rstWait.data", out_data,         32'd0);
      checkOutput("rstWait.rd",   {27'b0, out_rd},  32'd0);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      m_data_rvalid = 1'b1;
      m_data_rdata  = 32'hFFFFFFFF;
      @(negedge clk);
      m_data_rvalid = 1'b0;
      checkOutput("lateRvalid.valid", {31'b0, out_valid}, 32'd0);
      checkOutput("lateRvalid.data",  out_data,           32'd0);
      checkOutput("lateRvalid.err",   {31'b0, out_err},   32'd0);
      @(negedge clk);
      checkOutput("lateRvalid.valid2", {31'b0, out_valid}, 32'd0);
      checkOutput("lateRvalid.busy",   {31'b0, busy},      32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
